alu_cmd_sequencer: RTL and testbench

//  Issue stage wrapped around the 4-bit combinational ALU: buffers (a,b,op) commands in a FIFO,

---
 rtl/alu_cmd_sequencer_if.sv | 59 +++++
 rtl/alu_cmd_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result bundle for the ALU issue stage.
// slave  : the sequencer's view (accepts commands, drives the ALU, offers results).
// master : the surrounding environment's view (command source, external ALU, result sink).
// Ports:
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op   command channel, valid/ready
//   alu_a/alu_b/alu_op/alu_result            link to the external combinational ALU
//   res_valid/res_ready/res_data/res_op      result channel, valid/ready
//   busy                                     work pending anywhere in the stage
//   res_zero                                 only with ALU_SEQ_ZERO_FLAG_EN: registered (res_data == 0)
interface alu_cmd_sequencer_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [2:0]   cmd_op;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [2:0]   res_op;

  logic         busy;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic         res_zero;
`endif

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result,
    output res_valid, res_data, res_op,
    input  res_ready,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output res_zero,
`endif
    output busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result,
    input  res_valid, res_data, res_op,
    output res_ready,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    input  res_zero,
`endif
    input  busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Purpose: FIFO-buffered issue stage feeding an external combinational ALU, registered result out.
// Latency: command pushed at edge N issues at edge N+1 (empty FIFO, free sink); result seen cycle N+2.
// Backpressure: res_ready low freezes the result register and ALU head; cmd_ready = !full only.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (assert async, release expected synchronous)
//   bus    alu_cmd_sequencer_if.slave: command channel in, ALU link, result channel out, busy
// Parameters:
//   W      operand/result width, must match the external ALU
//   DEPTH  command FIFO entries, power of two, >= 2
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds bus.res_zero, a registered (res_data == 0).
module alu_cmd_sequencer #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  // Derived view of the stage; nothing here is stored, it is decoded from
  // FIFO occupancy, the result register and the sink's ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STALL = 2'd3
  } state_t;

  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          res_valid_q;
  logic [W-1:0]  res_data_q;
  logic [2:0]    res_op_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic          res_zero_q;
`endif

  logic   empty;
  logic   full;
  logic   push;
  logic   issue;
  cmd_t   head;
  cmd_t   cmd_in;
  state_t state;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_comb begin
    state = IDLE;
    if (empty) begin
      state = res_valid_q ? DRAIN : IDLE;
    end else if (res_valid_q && !bus.res_ready) begin
      state = STALL;
    end else begin
      state = RUN;
    end
  end

  // Push ignores a same-cycle pop: ready is a pure function of full.
  assign push  = bus.cmd_valid && !full;
  assign issue = (state == RUN);

  assign cmd_in = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};

  // The ALU sees the FIFO head, forced to zero when nothing is queued so the
  // combinational ALU never chews on a stale entry.
  always_comb begin
    head = '0;
    if (!empty) begin
      head = mem[rd_ptr[AW-1:0]];
    end
  end

  assign bus.alu_a  = head.a;
  assign bus.alu_b  = head.b;
  assign bus.alu_op = head.op;

  // Storage needs no reset: an entry is only observed between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= cmd_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      res_zero_q  <= 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (issue) begin
        // Capture the ALU output for the head and retire the head in one edge.
        rd_ptr      <= rd_ptr + PTR_ONE;
        res_valid_q <= 1'b1;
        res_data_q  <= bus.alu_result;
        res_op_q    <= head.op;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        res_zero_q  <= (bus.alu_result == '0);
`endif
      end else if (res_valid_q && bus.res_ready) begin
        // Data and tag stay put; only the valid drops once consumed.
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_op    = res_op_q;
  assign bus.busy      = (state != IDLE);
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign bus.res_zero  = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural stand-in for the external ALU.
module tb_alu_cmd_sequencer;
  localparam int W     = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.W(W)) bus ();

  alu_cmd_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External ALU model
  logic [3:0] alu_y;
  always_comb begin
    alu_y = 4'h0;
    case (bus.alu_op)
      3'b001:  alu_y = bus.alu_a + bus.alu_b;
      3'b010:  alu_y = bus.alu_a - bus.alu_b;
      3'b011:  alu_y = bus.alu_a & bus.alu_b;
      3'b100:  alu_y = bus.alu_a | bus.alu_b;
      3'b101:  alu_y = ~bus.alu_a;
      3'b110:  alu_y = ~bus.alu_b;
      default: alu_y = 4'h0;
    endcase
  end
  assign bus.alu_result = alu_y;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bus.cmd_valid = v;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    rst_n = 1'b0;
    drive_cmd(1'b0, 4'h0, 4'h0, 3'h0);
    bus.res_ready = 1'b0;
    step();
    step();
    obs = {bus.cmd_ready, bus.res_valid, bus.busy, bus.res_data, bus.res_op, bus.alu_a, bus.alu_b, bus.alu_op};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 3'h0}) begin
      n_fail++;
      $display("FAIL rst_initial obs=%h req=%h", obs, {1'b1, 1'b0, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 3'h0});
    end
    rst_n = 1'b1;
    // three commands queued behind a stalled sink
    drive_cmd(1'b1, 4'h1, 4'h1, 3'b001);
    step();
    drive_cmd(1'b1, 4'h2, 4'h2, 3'b001);
    step();
    drive_cmd(1'b1, 4'h3, 4'h3, 3'b001);
    step();
    n_checks++;
    if ({bus.res_valid, bus.busy, bus.res_data} !== {1'b1, 1'b1, 4'h2}) begin
      n_fail++;
      $display("FAIL rst_prestate got=%b/%b/%h req=1/1/2", bus.res_valid, bus.busy, bus.res_data);
    end
    drive_cmd(1'b0, 4'h0, 4'h0, 3'h0);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {bus.cmd_ready, bus.res_valid, bus.busy, bus.res_data, bus.res_op, bus.alu_a, bus.alu_b, bus.alu_op};
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 3'h0}) begin
      n_fail++;
      $display("FAIL rst_async obs=%h req=%h", obs, {1'b1, 1'b0, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 3'h0});
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    n_checks++;
    if (bus.res_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_zero got=%b req=0", bus.res_zero);
    end
`endif
    step();
    step();
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({bus.res_valid, bus.busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_after cyc=%0d vld/busy=%b req=00", i, {bus.res_valid, bus.busy});
      end
    end
  endtask

  task automatic test_single();
    bus.res_ready = 1'b1;
    drive_cmd(1'b1, 4'h3, 4'h4, 3'b001);
    step();
    drive_cmd(1'b0, 4'h0, 4'h0, 3'h0);
    n_checks++;
    if ({bus.res_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_op} !== {1'b0, 1'b1, 4'h3, 4'h4, 3'b001}) begin
      n_fail++;
      $display("FAIL single_head vld=%b busy=%b alu=%h/%h/%b req 0 1 3/4/001",
               bus.res_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    step();
    n_checks++;
    if ({bus.res_valid, bus.res_data, bus.res_op, bus.alu_a, bus.alu_op} !== {1'b1, 4'h7, 3'b001, 4'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL single_result vld=%b data=%h op=%b alu_a=%h alu_op=%b req 1 7 001 0 000",
               bus.res_valid, bus.res_data, bus.res_op, bus.alu_a, bus.alu_op);
    end
    step();
    n_checks++;
    if ({bus.res_valid, bus.busy, bus.res_data} !== {1'b0, 1'b0, 4'h7}) begin
      n_fail++;
      $display("FAIL single_drain vld=%b busy=%b data=%h req 0 0 7", bus.res_valid, bus.busy, bus.res_data);
    end
  endtask

  task automatic test_wrap();
    bus.res_ready = 1'b1;
    drive_cmd(1'b1, 4'hF, 4'h1, 3'b001);
    step();
    drive_cmd(1'b1, 4'h2, 4'h3, 3'b010);
    step();
    drive_cmd(1'b0, 4'h0, 4'h0, 3'h0);
    n_checks++;
    if ({bus.res_valid, bus.res_data, bus.res_op} !== {1'b1, 4'h0, 3'b001}) begin
      n_fail++;
      $display("FAIL wrap_add vld=%b data=%h op=%b req 1 0 001", bus.res_valid, bus.res_data, bus.res_op);
    end
`ifdef ALU_SEQ_ZERO_FLAG_EN
    n_checks++;
    if (bus.res_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_add_zero got=%b req=1", bus.res_zero);
    end
`endif
    step();
    n_checks++;
    if ({bus.res_valid, bus.res_data, bus.res_op} !== {1'b1, 4'hF, 3'b010}) begin
      n_fail++;
      $display("FAIL wrap_sub vld=%b data=%h op=%b req 1 F 010", bus.res_valid, bus.res_data, bus.res_op);
    end
    step();
    n_checks++;
    if (bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end vld=%b req=0", bus.res_valid);
    end
  endtask

  task automatic test_full();
    logic [3:0] fa [6];
    logic [3:0] fb [6];
    logic [2:0] fo [6];
    logic [3:0] fe [6];
    logic       rdy;
    int         acc;
    int         got;
    fa = '{4'h1, 4'h9, 4'hC, 4'h5, 4'h3, 4'h7};
    fb = '{4'h2, 4'h4, 4'hA, 4'hA, 4'h0, 4'h0};
    fo = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    fe = '{4'h3, 4'h5, 4'h8, 4'hF, 4'hC, 4'hF};
    acc = 0;
    got = 0;
    bus.res_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive_cmd(1'b1, fa[acc], fb[acc], fo[acc]);
      rdy = bus.cmd_ready;
      step();
      if (rdy) acc++;
    end
    n_checks++;
    if (acc !== DEPTH + 1) begin
      n_fail++;
      $display("FAIL full_accepted got=%0d req=%0d", acc, DEPTH + 1);
    end
    n_checks++;
    if ({bus.cmd_ready, bus.busy, bus.res_valid, bus.res_data} !== {1'b0, 1'b1, 1'b1, fe[0]}) begin
      n_fail++;
      $display("FAIL full_state rdy=%b busy=%b vld=%b data=%h req 0 1 1 %h",
               bus.cmd_ready, bus.busy, bus.res_valid, bus.res_data, fe[0]);
    end
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {fa[1], fb[1], fo[1]}) begin
      n_fail++;
      $display("FAIL full_stall_head alu=%h/%h/%b req %h/%h/%b",
               bus.alu_a, bus.alu_b, bus.alu_op, fa[1], fb[1], fo[1]);
    end
    // Release the sink while the sixth command is still offered on a full FIFO.
    bus.res_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 5) begin
        n_checks++;
        if (bus.res_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL full_burst_vld cyc=%0d got=%b req=1", cyc, bus.res_valid);
        end
      end
      if (bus.res_valid) begin
        n_checks++;
        if (got >= 5) begin
          n_fail++;
          $display("FAIL full_extra_result idx=%0d data=%h op=%b req none", got, bus.res_data, bus.res_op);
        end else if ({bus.res_data, bus.res_op} !== {fe[got], fo[got]}) begin
          n_fail++;
          $display("FAIL full_order idx=%0d data=%h op=%b req %h %b", got, bus.res_data, bus.res_op, fe[got], fo[got]);
        end
        got++;
      end
      step();
      if (cyc == 0) begin
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_nopush_on_pop rdy=%b req=1", bus.cmd_ready);
        end
        drive_cmd(1'b0, 4'h0, 4'h0, 3'h0);
      end
    end
    n_checks++;
    if ((got !== 5) || (bus.busy !== 1'b0)) begin
      n_fail++;
      $display("FAIL full_count results=%0d busy=%b req 5 0", got, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] sa [16];
    logic [3:0] sb [16];
    logic [2:0] so [16];
    logic [3:0] se [16];
    sa = '{4'h3, 4'h3, 4'h9, 4'hC, 4'h5, 4'h3, 4'h0, 4'hF, 4'hF, 4'h2, 4'hF, 4'h8, 4'hA, 4'h0, 4'h6, 4'h0};
    sb = '{4'h4, 4'h4, 4'h4, 4'hA, 4'hA, 4'h0, 4'h6, 4'hF, 4'h1, 4'h3, 4'h3, 4'h1, 4'h0, 4'hA, 4'h6, 4'h1};
    so = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
    se = '{4'h0, 4'h7, 4'h5, 4'h8, 4'hF, 4'hC, 4'h9, 4'h0, 4'h0, 4'hF, 4'h3, 4'h9, 4'h5, 4'h5, 4'hC, 4'hF};
    bus.res_ready = 1'b1;
    for (int s = 0; s < 17; s++) begin
      if (s < 16) drive_cmd(1'b1, sa[s], sb[s], so[s]);
      else        drive_cmd(1'b0, 4'h0, 4'h0, 3'h0);
      step();
      if (s >= 1) begin
        n_checks++;
        if ({bus.res_valid, bus.res_data, bus.res_op, bus.cmd_ready} !== {1'b1, se[s-1], so[s-1], 1'b1}) begin
          n_fail++;
          $display("FAIL stream idx=%0d vld=%b data=%h op=%b rdy=%b req 1 %h %b 1",
                   s - 1, bus.res_valid, bus.res_data, bus.res_op, bus.cmd_ready, se[s-1], so[s-1]);
        end
      end
    end
    step();
    n_checks++;
    if ({bus.res_valid, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL stream_end vld/busy=%b req=00", {bus.res_valid, bus.busy});
    end
  endtask

`ifdef ALU_SEQ_ZERO_FLAG_EN
  task automatic test_zero_flag();
    bus.res_ready = 1'b1;
    drive_cmd(1'b1, 4'h5, 4'h5, 3'b000);
    step();
    drive_cmd(1'b1, 4'hC, 4'h3, 3'b011);
    step();
    drive_cmd(1'b1, 4'h1, 4'h0, 3'b100);
    n_checks++;
    if ({bus.res_valid, bus.res_data, bus.res_zero} !== {1'b1, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_op0 vld=%b data=%h z=%b req 1 0 1", bus.res_valid, bus.res_data, bus.res_zero);
    end
    step();
    drive_cmd(1'b0, 4'h0, 4'h0, 3'h0);
    n_checks++;
    if ({bus.res_valid, bus.res_data, bus.res_zero} !== {1'b1, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_and vld=%b data=%h z=%b req 1 0 1", bus.res_valid, bus.res_data, bus.res_zero);
    end
    step();
    n_checks++;
    if ({bus.res_valid, bus.res_data, bus.res_zero} !== {1'b1, 4'h1, 1'b0}) begin
      n_fail++;
      $display("FAIL zero_or vld=%b data=%h z=%b req 1 1 0", bus.res_valid, bus.res_data, bus.res_zero);
    end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_full();
    test_back_to_back();
`ifdef ALU_SEQ_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
